uart_receiver: RTL and testbench

Asynchronous serial receiver: 8 data bits, LSB first, one stop bit, idle-high line. The TX pin of a remote transmitter drives it; a 16x oversampled mid-bit sampler recovers bytes and hands them to core logic through a one-entry valid/ready holding register. It runs alongside the existing UART transmitter at the same default rate, 250000 baud from a 100 MHz clock.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_receiver_if.sv | 32 +++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_receiver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: defaults, FSM state type, helpers.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_CLK_FREQ   = 100000000;
    localparam int UART_BAUD       = 250000;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_WAIT_HIGH = 3'd4,
        S_PARITY    = 3'd5
`else
        S_WAIT_HIGH = 3'd4
`endif
    } uart_rx_state_e;

    // Oversample tick divider, clamped so very fast baud settings still tick every cycle.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side handshake bundle of the UART receiver: byte, valid/ready and status pulses.
// PARITY_ERR exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      busy;
    logic                      frame_err;
    logic                      overrun;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err;
`endif

    modport master (
        output data, valid, busy, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  ready
    );

    modport slave (
        input  data, valid, busy, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: single-cycle registered tick every DIV clocks, with synchronous clear.
module uart_baud_tick #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
    // The tick is registered, so a clear restarts one count ahead to keep ticks DIV clocks after it.
    localparam logic [CW-1:0] RELOAD = CW'(1 % DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d  = RELOAD;
            tick_d = (DIV == 1);
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for an even-parity bit after the data bits and a PARITY_ERR pulse.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    uart_receiver_if.master   bus
);

    localparam int         DIV      = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] END_CNT  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                rst_sync_q, rst_sync_d;
    logic                      rst_int_n;
    logic [1:0]                rx_sync_q, rx_sync_d;
    logic                      rxs_s;
    logic                      tick_s, tick_clr_s, mid_tick_s, end_tick_s;
    uart_rx_state_e            state_q, state_d;
    logic [3:0]                sample_cnt_q, sample_cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_bit_q, par_bit_d;
    logic                      parity_err_q, parity_err_d;
`endif

    // Reset synchronizer: assertion is immediate, release is aligned to clk.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Two-flop line synchronizer, idle-high so reset never looks like a start bit.
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
    end

    // Line synchronizer flops.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= rx_sync_d;
        end
    end

    assign rxs_s = rx_sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_int_n),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    assign mid_tick_s = tick_s && (sample_cnt_q == MID_CNT);
    assign end_tick_s = tick_s && (sample_cnt_q == END_CNT);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rxs_s) state_d = S_START;
                else        state_d = S_IDLE;
            end
            S_START: begin
                if (mid_tick_s) state_d = rxs_s ? S_IDLE : S_DATA;
                else            state_d = S_START;
            end
            S_DATA: begin
                if (end_tick_s && (bit_idx_q == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (end_tick_s) state_d = S_STOP;
                else            state_d = S_PARITY;
            end
`endif
            S_STOP: begin
                // A low stop bit may be a break; wait for the line to recover before re-arming.
                if (end_tick_s) state_d = rxs_s ? S_IDLE : S_WAIT_HIGH;
                else            state_d = S_STOP;
            end
            S_WAIT_HIGH: begin
                if (rxs_s) state_d = S_IDLE;
                else       state_d = S_WAIT_HIGH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM datapath and output logic.
    always_comb begin
        tick_clr_s   = 1'b0;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        if (valid_q && bus.ready) valid_d = 1'b0;
        else                      valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (!rxs_s) begin
                    tick_clr_s   = 1'b1;
                    sample_cnt_d = 4'd0;
                    bit_idx_d    = 3'd0;
                end else begin
                    tick_clr_s   = 1'b0;
                end
            end
            S_START: begin
                if (mid_tick_s)  sample_cnt_d = 4'd0;
                else if (tick_s) sample_cnt_d = sample_cnt_q + 4'd1;
                else             sample_cnt_d = sample_cnt_q;
            end
            S_DATA: begin
                if (end_tick_s) begin
                    shift_d      = {rxs_s, shift_q[UART_DATA_BITS-1:1]};
                    sample_cnt_d = 4'd0;
                    bit_idx_d    = bit_idx_q + 3'd1;
                end else if (tick_s) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                end else begin
                    sample_cnt_d = sample_cnt_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (end_tick_s) begin
                    par_bit_d    = rxs_s;
                    sample_cnt_d = 4'd0;
                end else if (tick_s) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                end else begin
                    sample_cnt_d = sample_cnt_q;
                end
            end
`endif
            S_STOP: begin
                if (end_tick_s) begin
                    sample_cnt_d = 4'd0;
                    if (!rxs_s) begin
                        frame_err_d = 1'b1;
                    end else if (valid_q && !bus.ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = uart_parity(shift_q) ^ par_bit_q;
`endif
                    end
                end else if (tick_s) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                end else begin
                    sample_cnt_d = sample_cnt_q;
                end
            end
            S_WAIT_HIGH: begin
                sample_cnt_d = sample_cnt_q;
            end
            default: begin
                sample_cnt_d = 4'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sample_cnt_q <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 100 MHz / 250000 baud (400 clocks per bit), default 8N1 build.
module tb_uart_receiver;

    localparam int BIT_CLKS = 400;
    localparam int LAT_NOM  = 3803;
    localparam int LAT_TOL  = 25;

    logic clk;
    logic rst_n;
    logic rx;
    int   cyc;
    int   vec_cnt;
    int   err_cnt;

    int   valid_rises;
    int   valid_hi;
    int   fe_hi;
    int   ov_hi;
    int   last_rise_cyc;
    logic [7:0] last_rise_data;
    logic valid_prev;

    int   r0, h0, f0, o0, start_cyc, lat;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_FREQ   (100000000),
        .BAUD       (250000),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc            = 0;
        valid_rises    = 0;
        valid_hi       = 0;
        fe_hi          = 0;
        ov_hi          = 0;
        last_rise_cyc  = 0;
        last_rise_data = 8'h00;
        valid_prev     = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        valid_prev <= bus.valid;
        if (bus.valid && !valid_prev) begin
            valid_rises    <= valid_rises + 1;
            last_rise_cyc  <= cyc;
            last_rise_data <= bus.data;
        end
        if (bus.valid)     valid_hi <= valid_hi + 1;
        if (bus.frame_err) fe_hi    <= fe_hi + 1;
        if (bus.overrun)   ov_hi    <= ov_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic snap();
        r0 = valid_rises;
        h0 = valid_hi;
        f0 = fe_hi;
        o0 = ov_hi;
    endtask

    function automatic int lat_report(input int l);
        return ((l >= LAT_NOM - LAT_TOL) && (l <= LAT_NOM + LAT_TOL)) ? LAT_NOM : l;
    endfunction

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        rx        = 1'b1;
        bus.ready = 1'b0;
        wait_clks(5);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_data",  32'(bus.data),  32'h00);

        // Idle line after reset.
        rst_n = 1'b1;
        snap();
        wait_clks(1000);
        check("idle_valid", 32'(bus.valid), 32'd0);
        check("idle_busy",  32'(bus.busy),  32'd0);
        check("idle_data",  32'(bus.data),  32'h00);
        check("idle_errs",  32'((fe_hi - f0) + (ov_hi - o0)), 32'd0);

        // Single byte with the consumer always ready.
        bus.ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        wait_clks(50);
        lat = last_rise_cyc - start_cyc;
        check("a5_rises",   32'(valid_rises - r0), 32'd1);
        check("a5_width",   32'(valid_hi - h0),    32'd1);
        check("a5_data",    32'(last_rise_data),   32'hA5);
        check("a5_latency", 32'(lat_report(lat)),  32'(LAT_NOM));
        check("a5_busy",    32'(bus.busy),         32'd0);

        // Two back-to-back frames into a stalled consumer.
        bus.ready = 1'b0;
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(50);
        check("ovr_rises",   32'(valid_rises - r0), 32'd1);
        check("ovr_first",   32'(last_rise_data),   32'h00);
        check("ovr_pulse",   32'(ov_hi - o0),       32'd1);
        check("ovr_valid",   32'(bus.valid),        32'd1);
        check("ovr_data",    32'(bus.data),         32'h00);
        bus.ready = 1'b1;
        wait_clks(1);
        check("ovr_accept",  32'(bus.valid),        32'd0);

        // Short low glitch is rejected at the mid-start check.
        snap();
        rx = 1'b0;
        wait_clks(100);
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        wait_clks(50);
        rx = 1'b1;
        wait_clks(110);
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        wait_clks(4000);
        check("glitch_valid", 32'(valid_rises - r0), 32'd0);
        check("glitch_ferr",  32'(fe_hi - f0),       32'd0);

        // Bad stop bit followed by a long break, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0);
        wait_clks(2000);
        check("brk_busy",  32'(bus.busy),        32'd1);
        check("brk_valid", 32'(valid_rises - r0), 32'd0);
        rx = 1'b1;
        wait_clks(400);
        check("brk_idle",  32'(bus.busy),        32'd0);
        send_frame(8'h5A, 1'b1);
        wait_clks(50);
        check("fe_pulse",  32'(fe_hi - f0),       32'd1);
        check("fe_rises",  32'(valid_rises - r0), 32'd1);
        check("fe_data",   32'(bus.data),         32'h5A);

        // Reset during data bit 4, then a clean frame.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        rx = 1'b0;
        wait_clks(200);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_busy",  32'(bus.busy),  32'd0);
        check("mid_rst_data",  32'(bus.data),  32'h00);
        @(negedge clk);
        rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(20);
        snap();
        send_frame(8'h81, 1'b1);
        wait_clks(50);
        lat = last_rise_cyc - start_cyc;
        check("post_rst_rises", 32'(valid_rises - r0), 32'd1);
        check("post_rst_data",  32'(last_rise_data),   32'h81);
        check("post_rst_lat",   32'(lat_report(lat)),  32'(LAT_NOM));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
